// File: rtl/instr_readback.sv
// instr_readback: streams a contiguous byte range of instruction BRAM out as
// {addr[23:0], data[7:0]} packets on a valid/ready interface, using a small
// internal FIFO to absorb BRAM latency and downstream back-pressure.
// Optional macro INSTR_READBACK_CHKSUM_EN appends a {24'hFFFFFF, sum8} trailer
// after the data packets; done then waits until the trailer has been popped.
module instr_readback #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk_user,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [23:0] length,
  output logic        busy,
  output logic        done,
  output logic        mem_rd_en,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        pkt_valid,
  output logic [31:0] pkt_data,
  input  logic        pkt_ready
);

  localparam int unsigned AW    = 24;
  localparam int unsigned PW    = 32;
  localparam int unsigned PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cur_addr_q, cur_addr_d;
  logic [AW-1:0]      remaining_q, remaining_d;
  logic [AW-1:0]      issued_addr_q;
  logic               rd_q;
  logic [PW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               busy_d, done_d, mem_rd_en_d, pkt_valid_d;
  logic [AW-1:0]      mem_addr_d;
  logic [PW-1:0]      pkt_data_d;

  logic               start_ok, push, pop, trailer_push, trailer_ok, room;
  logic [PW-1:0]      push_word;
  logic [AW-1:0]      src_addr, src_rem;

`ifdef INSTR_READBACK_CHKSUM_EN
  logic [7:0]         sum_q;
  logic               trailer_sent_q;
`endif

  // Next-state, read issue, FIFO bookkeeping and registered-output prediction
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr;
    done_d       = 1'b0;
    busy_d       = 1'b0;
    trailer_push = 1'b0;
    trailer_ok   = 1'b1;
    push_word    = {issued_addr_q, mem_rdata};

    start_ok = (state_q == S_IDLE) && start;
    pop      = pkt_valid && pkt_ready;

`ifdef INSTR_READBACK_CHKSUM_EN
    // Trailer goes in once every data read has landed in the FIFO
    trailer_push = (state_q == S_DRAIN) && !done && !rd_q && !mem_rd_en &&
                   !trailer_sent_q && (count_q < CNT_W'(FIFO_DEPTH));
    trailer_ok   = trailer_sent_q;
    if (!rd_q) push_word = {24'hFFFFFF, sum_q};
`endif

    push     = rd_q || trailer_push;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    // Room is judged on next-cycle occupancy plus the read landing next cycle
    room = ({1'b0, count_d} + (CNT_W+1)'(mem_rd_en)) < (CNT_W+1)'(FIFO_DEPTH);

    src_addr = (state_q == S_IDLE) ? base_addr : cur_addr_q;
    src_rem  = (state_q == S_IDLE) ? length    : remaining_q;

    if ((start_ok && (length != '0)) || (state_q == S_READ)) begin
      state_d     = S_READ;
      cur_addr_d  = src_addr;
      remaining_d = src_rem;
      if (room) begin
        mem_rd_en_d = 1'b1;
        mem_addr_d  = src_addr;
        cur_addr_d  = src_addr + 24'd1;
        remaining_d = src_rem - 24'd1;
        if (src_rem == 24'd1) state_d = S_DRAIN;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok && (length == '0)) begin
`ifdef INSTR_READBACK_CHKSUM_EN
          state_d = S_DRAIN;
`else
          done_d  = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        if (done) begin
          state_d = S_IDLE;
        end else if ((count_d == '0) && !mem_rd_en && trailer_ok) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase

    busy_d      = (state_d != S_IDLE) && !done_d;
    pkt_valid_d = (count_d != '0);
    pkt_data_d  = (push && (wr_ptr_q == rd_ptr_d)) ? push_word : fifo_mem[rd_ptr_d];
  end

  // Control, pointer and output registers
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      issued_addr_q <= '0;
      rd_q          <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      pkt_valid     <= 1'b0;
      pkt_data      <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      issued_addr_q <= mem_addr;
      rd_q          <= mem_rd_en;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      busy          <= busy_d;
      done          <= done_d;
      mem_rd_en     <= mem_rd_en_d;
      mem_addr      <= mem_addr_d;
      pkt_valid     <= pkt_valid_d;
      pkt_data      <= pkt_data_d;
    end
  end

  // Packet storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_user) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

`ifdef INSTR_READBACK_CHKSUM_EN
  // Running byte sum and trailer bookkeeping
  always_ff @(posedge clk_user) begin
    if (reset) begin
      sum_q          <= '0;
      trailer_sent_q <= 1'b0;
    end else if (start_ok) begin
      sum_q          <= '0;
      trailer_sent_q <= 1'b0;
    end else begin
      if (rd_q)         sum_q          <= sum_q + mem_rdata;
      if (trailer_push) trailer_sent_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_readback.sv
// Directed, table-driven bench for instr_readback with a behavioural BRAM.
module tb_instr_readback;

`ifdef INSTR_READBACK_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH  = 4;
  localparam int BUDGET = 300;

  logic        clk_user = 1'b0;
  logic        reset, start, busy, done, mem_rd_en, pkt_valid, pkt_ready;
  logic [23:0] base_addr, length, mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] pkt_data;

  int checks = 0;
  int failures = 0;

  instr_readback #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk_user(clk_user), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .pkt_valid(pkt_valid),
    .pkt_data(pkt_data), .pkt_ready(pkt_ready)
  );

  always #5 clk_user = ~clk_user;

  function automatic logic [7:0] bram_fn(input logic [23:0] a);
    case (a)
      24'h000100: bram_fn = 8'h11;
      24'h000101: bram_fn = 8'h22;
      24'h000102: bram_fn = 8'h33;
      24'h000103: bram_fn = 8'h44;
      24'h000200: bram_fn = 8'h80;
      24'h000201: bram_fn = 8'h90;
      24'h000202: bram_fn = 8'h10;
      default:    bram_fn = a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk_user) mem_rdata <= mem_rd_en ? bram_fn(mem_addr) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  typedef struct {
    logic [23:0] base;
    logic [23:0] len;
    int          mode;   // 0 ready=1, 1 stall 10 then toggle, 2 random, 3 stray start
    logic [31:0] first;
    logic [31:0] last;
    logic [7:0]  sum;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    int got, issued, total, ndone;
    bit fin, prev_stall;
    logic [31:0] prev_data, exp_pkt, first_p, last_p;
    logic [23:0] exp_rd;
    got = 0; issued = 0; ndone = 0; fin = 0; prev_stall = 0;
    prev_data = '0; first_p = '0; last_p = '0;
    exp_rd = v.base;
    total = int'(v.len) + (CHK ? 1 : 0);
    start = 1'b1; base_addr = v.base; length = v.len;
    tick();
    start = 1'b0;
    if (v.len != 0) begin
      chk("first_rd_latency", {31'd0, mem_rd_en}, 32'd1);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
    end
    for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
      case (v.mode)
        0:       pkt_ready = 1'b1;
        1:       pkt_ready = (cyc < 10) ? 1'b0 : cyc[0];
        2:       pkt_ready = 1'($urandom_range(0, 1));
        default: begin
          pkt_ready = 1'b1;
          start     = (cyc == 2);
          base_addr = 24'h000777;
          length    = 24'd5;
        end
      endcase
      if (mem_rd_en) begin
        chk("rd_addr", {8'd0, mem_addr}, {8'd0, exp_rd});
        exp_rd = exp_rd + 24'd1;
        issued++;
      end
      if (v.mode == 1 && cyc == 9 && v.len >= 24'(DEPTH))
        chk("rd_stop_at_depth", issued, DEPTH);
      if (issued - got > DEPTH) chk("outstanding_bound", issued - got, DEPTH);
      if (prev_stall) chk("stall_stable", pkt_data, prev_data);
      if (pkt_valid && pkt_ready) begin
        if (got < int'(v.len)) begin
          exp_pkt = {v.base + 24'(got), bram_fn(v.base + 24'(got))};
          if (got == 0) first_p = pkt_data;
          if (got == int'(v.len) - 1) last_p = pkt_data;
        end else begin
          exp_pkt = {24'hFFFFFF, v.sum};
        end
        chk("pkt", pkt_data, exp_pkt);
        got++;
      end
      prev_stall = pkt_valid && !pkt_ready;
      prev_data  = pkt_data;
      if (done) begin
        ndone++;
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("pkts_before_done", got, total);
        fin = 1;
      end
      tick();
    end
    start = 1'b0;
    pkt_ready = 1'b1;
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_idle", {29'd0, done, busy, pkt_valid}, 32'd0);
      tick();
    end
    if (v.len != 0) begin
      chk("first_pkt", first_p, v.first);
      chk("last_pkt", last_p, v.last);
    end
  endtask

  vec_t tbl [7];

  initial begin
    int got;
    bit seen;
    tbl[0] = '{24'h000100, 24'd4, 0, 32'h00010011, 32'h00010344, 8'hAA};
    tbl[1] = '{24'h000100, 24'd8, 1, 32'h00010011, 32'h0001073A, 8'h90};
    tbl[2] = '{24'hFFFFFE, 24'd3, 0, 32'hFFFFFE3D, 32'h0000003C, 8'hB5};
    tbl[3] = '{24'h000200, 24'd3, 0, 32'h00020080, 32'h00020210, 8'h20};
    tbl[4] = '{24'h000100, 24'd4, 3, 32'h00010011, 32'h00010344, 8'hAA};
    tbl[5] = '{24'hFFFFFE, 24'd3, 2, 32'hFFFFFE3D, 32'h0000003C, 8'hB5};
    tbl[6] = '{24'h000050, 24'd1, 1, 32'h0000506C, 32'h0000506C, 8'h6C};

    reset = 1'b1; start = 1'b0; pkt_ready = 1'b0; base_addr = '0; length = '0;
    tick(); tick();
    chk("reset_outs", {29'd0, busy, done, mem_rd_en}, 32'd0);
    chk("reset_valid", {31'd0, pkt_valid}, 32'd0);
    chk("reset_data", pkt_data, 32'd0);
    chk("reset_addr", {8'd0, mem_addr}, 32'd0);
    reset = 1'b0; pkt_ready = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    // Zero-length transfer
`ifdef INSTR_READBACK_CHKSUM_EN
    run_xfer('{24'h000123, 24'd0, 0, 32'd0, 32'd0, 8'h00});
`else
    start = 1'b1; base_addr = 24'h000123; length = 24'd0;
    tick();
    start = 1'b0;
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("len0_quiet", {29'd0, done, mem_rd_en, pkt_valid}, 32'd0);
    end
`endif

    // Reset after two packets of an eight-byte transfer
    start = 1'b1; base_addr = 24'h000300; length = 24'd8; pkt_ready = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got < 2; c++) begin
      if (pkt_valid && pkt_ready) got++;
      if (got < 2) tick();
    end
    chk("mid_reset_reached", got, 2);
    reset = 1'b1;
    tick();
    chk("mid_reset_outs", {29'd0, busy, done, mem_rd_en}, 32'd0);
    chk("mid_reset_valid", {31'd0, pkt_valid}, 32'd0);
    chk("mid_reset_data", pkt_data, 32'd0);
    chk("mid_reset_addr", {8'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || pkt_valid || mem_rd_en || busy) seen = 1;
    end
    chk("after_reset_quiet", {31'd0, seen}, 32'd0);
    run_xfer('{24'h000400, 24'd2, 0, 32'h00040038, 32'h00040139, 8'h71});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_readback.md
Name: instr_readback

Overview:
- Readback engine for RISC-V instruction BRAM, running on clk_user.
- On a start command, reads a contiguous byte range from BRAM and emits one 32-bit packet per byte as {addr[23:0], data[7:0]}. This is the same packet format the instruction-load path consumes.
- Packets leave on a valid/ready stream toward the BFT-side transmit FIFO. An internal skid FIFO absorbs back-pressure and BRAM read latency.

Parameters:
- FIFO_DEPTH, 4, entries in internal packet buffer; power of two, minimum 2.
- CNT_W, 3, width of occupancy counter; equals log2(FIFO_DEPTH)+1.

Ports:
- clk_user  input  1  user clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  input  24  first byte address, latched on accepted start.
- length  input  24  byte count, latched on accepted start; 0 is legal.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the transfer is complete.
- mem_rd_en  output  1  BRAM read strobe.
- mem_addr  output  24  BRAM byte address, valid with mem_rd_en.
- mem_rdata  input  8  BRAM data, valid exactly 1 cycle after mem_rd_en.
- pkt_valid  output  1  packet available.
- pkt_data  output  32  {addr, data}; stable while pkt_valid && !pkt_ready.
- pkt_ready  input  1  downstream accepts the packet when pkt_valid && pkt_ready.

Behaviour:
- Reset (synchronous, active-high, clk_user):
  - busy=0, done=0, mem_rd_en=0, mem_addr=0, pkt_valid=0, pkt_data=0.
  - FIFO emptied, in-flight read flag cleared, FSM=IDLE.
  - Reset mid-transfer aborts immediately: no done pulse; any in-flight BRAM data is discarded.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start && length!=0: latch base_addr into cur_addr and length into remaining; busy=1 next cycle; go to READ.
  - start && length==0: done pulses next cycle; busy stays 0; remain IDLE.
- READ:
  - Issue condition: (fifo_count + inflight) < FIFO_DEPTH.
  - When the issue condition holds, assert mem_rd_en with mem_addr=cur_addr. Then cur_addr <= cur_addr+1 (24-bit wrap, 0xFFFFFF -> 0x000000) and remaining <= remaining-1.
  - At most one read per cycle; back-to-back reads allowed, giving 1 packet/cycle with pkt_ready held high.
  - After the issue with remaining==1, go to DRAIN.
- Read return:
  - One cycle after mem_rd_en, push {issued_addr, mem_rdata} into the FIFO. issued_addr is the registered copy of mem_addr.
  - Overflow is impossible by the issue rule.
- DRAIN:
  - No new reads.
  - When the FIFO is empty, no read is in flight, and no push is pending: done=1 for one cycle, busy=0 the same cycle, go to IDLE.
- Output stream:
  - pkt_valid = FIFO not empty; pkt_data = FIFO head.
  - Pop on pkt_valid && pkt_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - pkt_data never changes while pkt_valid && !pkt_ready.
- Ordering: packets are emitted in strictly ascending address order (modulo 2^24), exactly length packets per transfer.
- start while busy: ignored, no effect on latched state.
- start in the same cycle as the done pulse: ignored, because the FSM is not yet in IDLE. It is accepted on the next cycle.
- Latency: accepted start -> first mem_rd_en = 1 cycle; mem_rd_en -> pkt_valid = 2 cycles (BRAM + FIFO register).

Optional Feature:
- Macro: INSTR_READBACK_CHKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every data byte of the transfer; it is cleared on accepted start.
  - In DRAIN, after the last data packet is pushed, push one trailer packet {24'hFFFFFF, sum[7:0]} when FIFO space exists.
  - done waits until the trailer has been popped.
  - length==0 still emits a trailer {24'hFFFFFF, 8'h00} before done.
- Not defined: no accumulator and no trailer; exactly length packets per transfer.

Test Plan:
- base_addr=0x000100, length=4, BRAM[0x100..0x103]=11,22,33,44, pkt_ready=1 -> packets 0x00010011, 0x00010122, 0x00010233, 0x00010344 on consecutive cycles; done pulses once; busy low after.
- Same transfer with pkt_ready low for 10 cycles, then toggled every other cycle -> mem_rd_en stops after FIFO_DEPTH outstanding; no packet lost or duplicated; pkt_data stable while stalled.
- base_addr=0xFFFFFE, length=3 -> packet addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
- start with length=0 -> done pulse 1 cycle later; no mem_rd_en, no pkt_valid. Start pulsed mid-transfer -> ignored; packet count unchanged.
- Reset asserted after 2 of 8 packets -> all outputs 0 next cycle, no done pulse; a new start with length=2 afterwards yields exactly 2 correct packets.
- INSTR_READBACK_CHKSUM_EN defined, bytes 0x80, 0x90, 0x10 -> data packets followed by trailer 0xFFFFFF20; done only after the trailer is popped.
